// File: rtl/float_divider_seq.sv
// Sequential IEEE-754 single-precision divider: radix-2 restoring division, one quotient bit per clock.
// Optional macro FDIV_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module float_divider_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    exception,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              fsm_state
);

  // Handshake: start is taken only in IDLE; busy is high UNPACK..ROUND; done pulses one cycle
  // with result/flags already valid, and they hold until the next completion overwrites them.

  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int SIG_W = MANT_W + 1;
  localparam int Q_W   = MANT_W + 3;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(Q_W);

  localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(Q_W - 1);
  localparam logic signed [E_W-1:0] BIAS      = E_W'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [E_W-1:0] EMAX      = E_W'(2 ** EXP_W - 1);
  localparam logic signed [E_W-1:0] ZERO_E    = '0;
  localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
  localparam logic [W-1:0]          QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIVIDE = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_n;

  logic [W-1:0]            a_q, b_q;
  logic                    sign_q;
  logic signed [E_W-1:0]   exp_q;
  logic [SIG_W-1:0]        divisor_q;
  logic [Q_W-1:0]          rem_q, quot_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic              sign_ab;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              spec_hit, spec_exc;
  logic [W-1:0]      spec_res;

  logic [Q_W-1:0]        div_ext, rem_sub, rem_next, quot_next;
  logic                  rem_ge;
  logic [MANT_W-1:0]     frac_out;
  logic signed [E_W-1:0] exp_rnd;
  logic                  ovf_c, unf_c;
  logic [W-1:0]          packed_res;

  assign fsm_state = state;

  assign ea      = a_q[W-2:MANT_W];
  assign eb      = b_q[W-2:MANT_W];
  assign fa      = a_q[MANT_W-1:0];
  assign fb      = b_q[MANT_W-1:0];
  assign sign_ab = a_q[W-1] ^ b_q[W-1];

  // Exponent field 0 means zero regardless of fraction: denormals are flushed on input.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  always_comb begin
    spec_hit = 1'b1;
    spec_exc = 1'b1;
    spec_res = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
    end else if (a_inf || b_zero) begin
      spec_res = {sign_ab, EXP_ONES, {MANT_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      spec_res = {sign_ab, {(W-1){1'b0}}};
      spec_exc = 1'b0;
    end else begin
      spec_hit = 1'b0;
      spec_exc = 1'b0;
    end
  end

  // One restoring step: subtract when possible, record the quotient bit, shift the remainder.
  assign div_ext   = {{(Q_W-SIG_W){1'b0}}, divisor_q};
  assign rem_ge    = (rem_q >= div_ext);
  assign rem_sub   = rem_ge ? (rem_q - div_ext) : rem_q;
  assign rem_next  = rem_sub << 1;
  assign quot_next = {quot_q[Q_W-2:0], rem_ge};

`ifdef FDIV_ROUND_NEAREST_EN
  logic             sticky_q;
  logic             round_up;
  logic [SIG_W:0]   mant_rnd;
  logic             hidden_unused;

  // quot_q[1] is the guard bit, quot_q[0] the round bit.
  assign round_up      = quot_q[1] & (quot_q[0] | sticky_q | quot_q[2]);
  assign mant_rnd      = {1'b0, quot_q[Q_W-1:2]} + {{SIG_W{1'b0}}, round_up};
  assign frac_out      = mant_rnd[SIG_W] ? '0 : mant_rnd[MANT_W-1:0];
  assign exp_rnd       = exp_q + {{(E_W-1){1'b0}}, mant_rnd[SIG_W]};
  assign hidden_unused = mant_rnd[MANT_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else if (state == S_DIVIDE && cnt_q == LAST_ITER) begin
      sticky_q <= |rem_sub;
    end
  end
`else
  logic [1:0] grd_unused;

  assign frac_out   = quot_q[Q_W-2:2];
  assign exp_rnd    = exp_q;
  assign grd_unused = quot_q[1:0];
`endif

  always_comb begin
    ovf_c = (exp_rnd >= EMAX);
    unf_c = !ovf_c && (exp_rnd <= ZERO_E);
    if (ovf_c) begin
      packed_res = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
    end else if (unf_c) begin
      packed_res = {sign_q, {(W-1){1'b0}}};
    end else begin
      packed_res = {sign_q, exp_rnd[EXP_W-1:0], frac_out};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_n = S_UNPACK;
      S_UNPACK: begin
        busy    = 1'b1;
        state_n = spec_hit ? S_DONE : S_DIVIDE;
      end
      S_DIVIDE: begin
        busy = 1'b1;
        if (cnt_q == LAST_ITER) state_n = S_NORM;
      end
      S_NORM: begin
        busy    = 1'b1;
        state_n = S_ROUND;
      end
      S_ROUND: begin
        busy    = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      result    <= '0;
      exception <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        S_UNPACK: begin
          if (spec_hit) begin
            result    <= spec_res;
            exception <= spec_exc;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else begin
            sign_q    <= sign_ab;
            exp_q     <= $signed({{(E_W-EXP_W){1'b0}}, ea}) - $signed({{(E_W-EXP_W){1'b0}}, eb}) + BIAS;
            divisor_q <= {1'b1, fb};
            rem_q     <= {{(Q_W-SIG_W){1'b0}}, 1'b1, fa};
            quot_q    <= '0;
            cnt_q     <= '0;
          end
        end
        S_DIVIDE: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        S_NORM: begin
          // Quotient lies in (0.5, 2): at most one left shift restores the leading one.
          if (!quot_q[Q_W-1]) begin
            quot_q <= quot_q << 1;
            exp_q  <= exp_q - E_W'(1);
          end
        end
        S_ROUND: begin
          result    <= packed_res;
          exception <= 1'b0;
          overflow  <= ovf_c;
          underflow <= unf_c;
        end
        default: ;
      endcase
    end
  end

endmodule
